// File: rtl/jtkiwi_romarb_if.sv
// ----------------------------------------------------------------------------
// jtkiwi_romarb_if : tile/object fetch channels and shared SDRAM ROM port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jtkiwi_romarb_if;
  logic        tile_cs;
  logic [17:0] tile_addr;
  logic [31:0] tile_data;
  logic        tile_ok;

  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;

  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;

  // Arbiter side: serves both fetchers and drives the SDRAM request
  modport slave (
    input  tile_cs, tile_addr, obj_cs, obj_addr, rom_data, rom_ok,
    output tile_data, tile_ok, obj_data, obj_ok, rom_addr, rom_cs
  );

  // Environment side: fetch engines plus SDRAM controller
  modport master (
    output tile_cs, tile_addr, obj_cs, obj_addr, rom_data, rom_ok,
    input  tile_data, tile_ok, obj_data, obj_ok, rom_addr, rom_cs
  );
endinterface

`default_nettype wire

// File: rtl/jtkiwi_romarb.sv
// ----------------------------------------------------------------------------
// jtkiwi_romarb : tile/object arbiter for the single graphics ROM SDRAM slot
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtkiwi_romarb #(
  parameter int unsigned BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  jtkiwi_romarb_if.slave  bus
);

  localparam logic [3:0] BURST_MAX = 4'(BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic [3:0]  burst_cnt, burst_nx;
  logic        first, first_nx;
  logic        rom_cs_nx;
  logic [17:0] rom_addr_nx;
  logic [17:0] tile_last, obj_last;

  logic        tile_pend, obj_pend, tile_win;
  logic        own_cs;
  logic [17:0] own_addr;
  logic        abort, done;
  logic        tile_done, obj_done;

  always_comb begin
    tile_pend = bus.tile_cs & ~bus.tile_ok;
    obj_pend  = bus.obj_cs  & ~bus.obj_ok;
    tile_win  = tile_pend & ~(obj_pend & (burst_cnt == BURST_MAX));
    own_cs    = owner ? bus.obj_cs   : bus.tile_cs;
    own_addr  = owner ? bus.obj_addr : bus.tile_addr;
    abort     = ~own_cs | (own_addr != bus.rom_addr);
    // rom_ok may still reflect the previous address during the first BUSY cycle
    done      = ~first & bus.rom_ok;
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    burst_nx    = burst_cnt;
    first_nx    = 1'b0;
    rom_cs_nx   = 1'b0;
    rom_addr_nx = bus.rom_addr;
    tile_done   = 1'b0;
    obj_done    = 1'b0;
    case (state)
      IDLE: begin
        if (tile_pend | obj_pend) begin
          state_nx  = BUSY;
          first_nx  = 1'b1;
          rom_cs_nx = 1'b1;
          if (tile_win) begin
            owner_nx    = 1'b0;
            rom_addr_nx = bus.tile_addr;
            if (!obj_pend)
              burst_nx = 4'd0;
            else if (burst_cnt < BURST_MAX)
              burst_nx = burst_cnt + 4'd1;
          end else begin
            owner_nx    = 1'b1;
            rom_addr_nx = bus.obj_addr;
            burst_nx    = 4'd0;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_nx = GAP;
        end else if (done) begin
          state_nx  = GAP;
          tile_done = ~owner;
          obj_done  = owner;
        end else begin
          rom_cs_nx = 1'b1;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      burst_cnt    <= 4'd0;
      first        <= 1'b0;
      bus.rom_cs   <= 1'b0;
      bus.rom_addr <= 18'd0;
    end else begin
      state        <= state_nx;
      owner        <= owner_nx;
      burst_cnt    <= burst_nx;
      first        <= first_nx;
      bus.rom_cs   <= rom_cs_nx;
      bus.rom_addr <= rom_addr_nx;
    end
  end

  // ok stays up only while the channel keeps asking for the address last fetched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tile_ok   <= 1'b0;
      bus.tile_data <= 32'd0;
      tile_last     <= 18'd0;
    end else if (tile_done) begin
      bus.tile_ok   <= 1'b1;
      bus.tile_data <= bus.rom_data;
      tile_last     <= bus.rom_addr;
    end else if (~bus.tile_cs | (bus.tile_addr != tile_last)) begin
      bus.tile_ok   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.obj_ok   <= 1'b0;
      bus.obj_data <= 32'd0;
      obj_last     <= 18'd0;
    end else if (obj_done) begin
      bus.obj_ok   <= 1'b1;
      bus.obj_data <= bus.rom_data;
      obj_last     <= bus.rom_addr;
    end else if (~bus.obj_cs | (bus.obj_addr != obj_last)) begin
      bus.obj_ok   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtkiwi_romarb.sv
// ----------------------------------------------------------------------------
// tb_jtkiwi_romarb : directed and randomized scoreboard bench for jtkiwi_romarb
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jtkiwi_romarb;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtkiwi_romarb_if bus();

  jtkiwi_romarb #(.BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] tq[$];
  logic [31:0] oq[$];
  int sd_mode;     // 0: stale-then-latency SDRAM, 1: ok held high with 0xDEADBEEF, 2: ok held low
  int sd_maxwait;

  function automatic logic [31:0] memf(input logic [17:0] a);
    return {a[13:0], a} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit is_obj, input logic cs, input logic [17:0] a);
    if (is_obj) begin
      bus.obj_cs   = cs;
      bus.obj_addr = a;
    end else begin
      bus.tile_cs   = cs;
      bus.tile_addr = a;
    end
  endtask

  // Wait (bounded) for the channel's ok to be seen low and then high
  task automatic wait_ok(input bit is_obj, input string name);
    bit   seen_low = 0;
    bit   got = 0;
    logic okv;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      okv = is_obj ? bus.obj_ok : bus.tile_ok;
      if (!okv) seen_low = 1;
      else if (seen_low) got = 1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  // SDRAM model: on a new request it keeps the previous (stale) rom_ok/rom_data
  // for one cycle, then waits a random number of cycles before valid data.
  task automatic sdram();
    logic prev = 1'b0;
    int   w = 0;
    forever begin
      @(posedge clk); #1;
      if (sd_mode == 1) begin
        bus.rom_ok   = 1'b1;
        bus.rom_data = 32'hDEADBEEF;
      end else if (sd_mode == 2) begin
        bus.rom_ok   = 1'b0;
        bus.rom_data = $urandom;
      end else if (bus.rom_cs && !prev) begin
        w = $urandom_range(0, sd_maxwait);
      end else if (bus.rom_cs) begin
        if (w == 0) begin
          bus.rom_ok   = 1'b1;
          bus.rom_data = memf(bus.rom_addr);
        end else begin
          w--;
          bus.rom_ok   = 1'b0;
          bus.rom_data = $urandom;
        end
      end
      prev = bus.rom_cs;
    end
  endtask

  task automatic completion(input bit ch, input logic [31:0] data, input logic own,
                            input int age, input logic fell);
    int n;
    logic [31:0] e;
    check(ch ? "obj_done_owner" : "tile_done_owner", 32'(own), 32'(ch));
    check("done_latency", 32'(age >= 2), 32'd1);
    check("done_cs_drop", 32'(fell), 32'd1);
    n = ch ? oq.size() : tq.size();
    check(ch ? "obj_queue_nonempty" : "tile_queue_nonempty", 32'(n != 0), 32'd1);
    if (n != 0) begin
      e = ch ? oq.pop_front() : tq.pop_front();
      check(ch ? "obj_data" : "tile_data", data, e);
    end
  endtask

  // Monitor: checks every grant against the priority/burst rules and every
  // ok rising edge against the scoreboard queues.
  task automatic monitor();
    logic s_tcs = 0, s_tok = 0, s_ocs = 0, s_ook = 0;
    logic [17:0] s_ta = 0, s_oa = 0;
    logic p_cs = 0, p_tok = 0, p_ook = 0, own = 0;
    logic t_p, o_p, w_obj;
    int streak = 0, low = 2, age = 0;
    forever begin
      @(negedge clk);
      s_tcs = bus.tile_cs; s_tok = bus.tile_ok; s_ta = bus.tile_addr;
      s_ocs = bus.obj_cs;  s_ook = bus.obj_ok;  s_oa = bus.obj_addr;
      @(posedge clk); #1;
      if (rst) begin
        streak = 0; p_cs = 0; p_tok = 0; p_ook = 0; low = 2; age = 0;
        continue;
      end
      if (p_cs) age++;
      if (bus.rom_cs && !p_cs) begin
        t_p = s_tcs && !s_tok;
        o_p = s_ocs && !s_ook;
        check("grant_pending", 32'(t_p | o_p), 32'd1);
        w_obj = !(t_p && !(o_p && streak >= BURST));
        check("grant_addr", 32'(bus.rom_addr), 32'(w_obj ? s_oa : s_ta));
        check("grant_gap", 32'(low >= 2), 32'd1);
        if (w_obj || !o_p) streak = 0;
        else if (streak < BURST) streak++;
        own = w_obj;
        age = 0;
      end
      if (bus.tile_ok && !p_tok) completion(1'b0, bus.tile_data, own, age, p_cs && !bus.rom_cs);
      if (bus.obj_ok  && !p_ook) completion(1'b1, bus.obj_data,  own, age, p_cs && !bus.rom_cs);
      if (!bus.rom_cs) low++;
      else low = 0;
      p_cs = bus.rom_cs; p_tok = bus.tile_ok; p_ook = bus.obj_ok;
    end
  endtask

  task automatic chan_run(input bit is_obj, input int n);
    logic [17:0] a, cur, base;
    base = is_obj ? 18'h20000 : 18'h00000;
    cur  = base;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) begin
        drive(is_obj, 1'b0, cur);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        a = base | 18'($urandom_range(0, 15));
      end else begin
        do a = base | 18'($urandom_range(0, 15)); while (a == cur);
      end
      if (is_obj) oq.push_back(memf(a));
      else        tq.push_back(memf(a));
      drive(is_obj, 1'b1, a);
      cur = a;
      wait_ok(is_obj, is_obj ? "obj_done_wait" : "tile_done_wait");
    end
    drive(is_obj, 1'b0, cur);
  endtask

  initial begin
    int cs_cnt, addr_bad, t_rise, o_rise, g1, g2, ngr, tgr;
    bit obj_granted, seen;
    logic pcs, ptok, pook;
    logic [17:0] ta;

    rst = 1'b1;
    sd_mode = 0; sd_maxwait = 0;
    bus.tile_cs = 0; bus.tile_addr = 0; bus.obj_cs = 0; bus.obj_addr = 0;
    bus.rom_ok = 0;  bus.rom_data = 0;
    fork
      sdram();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_rom_cs",    32'(bus.rom_cs),   32'd0);
    check("reset_rom_addr",  32'(bus.rom_addr), 32'd0);
    check("reset_tile_ok",   32'(bus.tile_ok),  32'd0);
    check("reset_obj_ok",    32'(bus.obj_ok),   32'd0);
    check("reset_tile_data", bus.tile_data,     32'd0);
    check("reset_obj_data",  bus.obj_data,      32'd0);

    // Single tile fetch with rom_ok held high throughout
    rst = 1'b0;
    sd_mode = 1;
    tq.push_back(32'hDEADBEEF);
    drive(0, 1'b1, 18'h01234);
    cs_cnt = 0; addr_bad = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (bus.rom_cs) begin
        cs_cnt++;
        if (bus.rom_addr != 18'h01234) addr_bad++;
      end
      if (i == 2) check("single_ok_not_early", 32'(bus.tile_ok), 32'd0);
      if (i == 3) begin
        check("single_tile_ok", 32'(bus.tile_ok), 32'd1);
        check("single_tile_data", bus.tile_data, 32'hDEADBEEF);
      end
    end
    check("single_rom_cs_cycles", 32'(cs_cnt), 32'd2);
    check("single_rom_addr", 32'(addr_bad), 32'd0);
    check("single_obj_ok", 32'(bus.obj_ok), 32'd0);
    drive(0, 1'b0, 18'h01234);
    sd_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Simultaneous requests
    tq.push_back(memf(18'h00010));
    oq.push_back(memf(18'h20000));
    drive(0, 1'b1, 18'h00010);
    drive(1, 1'b1, 18'h20000);
    t_rise = -100; o_rise = 0; g1 = -1; g2 = -1; ngr = 0;
    pcs = 0; ptok = 0; pook = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.rom_cs && !pcs) begin
        if (ngr == 0) g1 = int'(bus.rom_addr);
        else if (ngr == 1) g2 = int'(bus.rom_addr);
        ngr++;
      end
      if (bus.tile_ok && !ptok) t_rise = i;
      if (bus.obj_ok && !pook) o_rise = i;
      pcs = bus.rom_cs; ptok = bus.tile_ok; pook = bus.obj_ok;
    end
    check("simul_first_grant", 32'(g1), 32'h00010);
    check("simul_second_grant", 32'(g2), 32'h20000);
    check("simul_obj_after_tile", 32'(o_rise - t_rise), 32'd4);
    drive(0, 1'b0, 18'h00010);
    drive(1, 1'b0, 18'h20000);
    repeat (3) @(posedge clk);
    #1;

    // Starvation guard: tile reissues after every completion, obj held
    ta = 18'h00040;
    tq.push_back(memf(ta));
    oq.push_back(memf(18'h30000));
    drive(0, 1'b1, ta);
    drive(1, 1'b1, 18'h30000);
    tgr = 0; obj_granted = 0; pcs = 0; ptok = 0;
    for (int i = 0; i < 80 && !obj_granted; i++) begin
      @(posedge clk); #1;
      if (bus.rom_cs && !pcs) begin
        if (bus.rom_addr == 18'h30000) obj_granted = 1;
        else tgr++;
      end
      if (bus.tile_ok && !ptok) begin
        ta = ta + 18'd1;
        tq.push_back(memf(ta));
        drive(0, 1'b1, ta);
      end
      pcs = bus.rom_cs; ptok = bus.tile_ok;
    end
    check("starve_obj_granted", 32'(obj_granted), 32'd1);
    check("starve_tile_grants", 32'(tgr), 32'(BURST));
    wait_ok(1, "starve_obj_done");
    wait_ok(0, "starve_tile_after_obj");
    drive(0, 1'b0, ta);
    drive(1, 1'b0, 18'h30000);
    repeat (3) @(posedge clk);
    #1;

    // Abort: obj address changes while BUSY with rom_ok held low
    sd_mode = 2;
    drive(1, 1'b1, 18'h21111);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rom_cs) seen = 1;
    end
    check("abort_granted", 32'(seen), 32'd1);
    oq.push_back(memf(18'h22222));
    drive(1, 1'b1, 18'h22222);
    @(posedge clk); #1;
    check("abort_gap_cs", 32'(bus.rom_cs), 32'd0);
    check("abort_obj_ok", 32'(bus.obj_ok), 32'd0);
    check("abort_obj_data", bus.obj_data, memf(18'h30000));
    sd_mode = 0;
    wait_ok(1, "abort_refetch");
    check("abort_refetch_data", bus.obj_data, memf(18'h22222));

    // ok tracking: hold the address, then move it by one word
    tq.push_back(memf(18'h00100));
    drive(0, 1'b1, 18'h00100);
    wait_ok(0, "track_first_fetch");
    cs_cnt = 0; addr_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.rom_cs) cs_cnt++;
      if (!bus.tile_ok) addr_bad++;
    end
    check("track_ok_held", 32'(addr_bad), 32'd0);
    check("track_no_rom_cs", 32'(cs_cnt), 32'd0);
    tq.push_back(memf(18'h00101));
    drive(0, 1'b1, 18'h00101);
    @(posedge clk); #1;
    check("track_ok_drop", 32'(bus.tile_ok), 32'd0);
    @(posedge clk); #1;
    check("track_refetch_cs", 32'(bus.rom_cs), 32'd1);
    check("track_refetch_addr", 32'(bus.rom_addr), 32'h00101);
    wait_ok(0, "track_refetch_done");

    // Asynchronous reset in the middle of a BUSY transaction
    sd_mode = 2;
    tq.push_back(memf(18'h02222));
    drive(0, 1'b1, 18'h02222);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rom_cs) seen = 1;
    end
    check("areset_busy_reached", 32'(seen), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("areset_rom_cs", 32'(bus.rom_cs), 32'd0);
    check("areset_tile_ok", 32'(bus.tile_ok), 32'd0);
    check("areset_obj_ok", 32'(bus.obj_ok), 32'd0);
    oq.push_back(memf(18'h22222));
    @(posedge clk);
    #2 rst = 1'b0;
    sd_mode = 0;
    wait_ok(0, "areset_tile_regrant");
    wait_ok(1, "areset_obj_regrant");
    drive(0, 1'b0, 18'h02222);
    drive(1, 1'b0, 18'h22222);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic on both channels with random SDRAM latency
    sd_maxwait = 3;
    fork
      chan_run(1'b0, 40);
      chan_run(1'b1, 40);
    join
    repeat (10) @(posedge clk);
    #1;
    check("tile_queue_empty", 32'(tq.size()), 32'd0);
    check("obj_queue_empty",  32'(oq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
